// File: rtl/riscv_m_pkg.sv
// Constants and state encoding shared by the RV32M multiplier and divider.
// Both units use the same four-state handshake sequence.
package riscv_m_pkg;

    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT32_MIN     = 32'h8000_0000;
    localparam logic [31:0] NEG_ONE       = 32'hFFFF_FFFF;

    localparam logic [1:0] ST_START    = 2'b00;
    localparam logic [1:0] ST_DIV      = 2'b01;
    localparam logic [1:0] ST_FINALIZE = 2'b10;
    localparam logic [1:0] ST_DONE     = 2'b11;

    typedef enum logic [1:0] {
        S_START    = ST_START,
        S_DIV      = ST_DIV,
        S_FINALIZE = ST_FINALIZE,
        S_DONE     = ST_DONE
    } md_state_e;

    localparam logic [4:0] DIV_LAST_STEP = 5'd31;

    // Magnitude of a two's complement value; INT32_MIN maps to 2^31 read as unsigned.
    function automatic logic [31:0] abs_if(input logic [31:0] v, input logic en);
        return (en && v[31]) ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic en);
        return en ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring shift-subtract step: shift the next dividend bit into the
// partial remainder and keep the difference only when it does not go negative.
module divider_step (
    input  logic [31:0] rem_i,
    input  logic        dvd_msb_i,
    input  logic [31:0] dvs_i,
    output logic [31:0] rem_o,
    output logic        q_bit_o
);

    logic [32:0] shifted;
    logic [32:0] trial;

    assign shifted = {rem_i, dvd_msb_i};
    assign trial   = shifted - {1'b0, dvs_i};

    // The partial remainder stays below the divisor, so a kept result fits in 32 bits.
    assign q_bit_o = ~trial[32];
    assign rem_o   = trial[32] ? shifted[31:0] : trial[31:0];

endmodule

// File: rtl/divider.sv
// Sequential RV32M divider (DIV/DIVU/REM/REMU) with a stb/cyc/ack handshake.
// One restoring step per clock; divide-by-zero and signed overflow skip the loop.
module divider
    import riscv_m_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        stb_i,
    input  logic        cyc_i,
    input  logic [31:0] op_1_i,
    input  logic [31:0] op_2_i,
    input  logic        is_signed_i,
    input  logic        result_rem_i,
    output logic [31:0] result_o,
    output logic        ack_o
);

    md_state_e   state_q;
    logic        sync_ack_q;
    logic [31:0] result_q;
    logic [31:0] quo_q;
    logic [31:0] rem_q;
    logic [31:0] dvd_q;
    logic [31:0] dvs_q;
    logic [4:0]  count_q;
    logic        rem_sel_q;
    logic        neg_q_q;
    logic        neg_r_q;

    logic [31:0] step_rem;
    logic        step_q_bit;
    logic        start_req;
    logic        div_zero;
    logic        overflow;

    assign start_req = stb_i & cyc_i & ~sync_ack_q;
    assign div_zero  = (op_2_i == 32'd0);
    assign overflow  = is_signed_i & (op_1_i == INT32_MIN) & (op_2_i == NEG_ONE);

    divider_step u_step (
        .rem_i     (rem_q),
        .dvd_msb_i (dvd_q[31]),
        .dvs_i     (dvs_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_q_bit)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_START;
            sync_ack_q <= 1'b0;
            result_q   <= 32'd0;
            quo_q      <= 32'd0;
            rem_q      <= 32'd0;
            dvd_q      <= 32'd0;
            dvs_q      <= 32'd0;
            count_q    <= 5'd0;
            rem_sel_q  <= 1'b0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
        end else begin
            case (state_q)
                S_START: begin
                    // Ack stays up while the requester keeps stb_i high.
                    sync_ack_q <= sync_ack_q & stb_i;
                    if (start_req) begin
                        rem_sel_q <= result_rem_i;
                        neg_q_q   <= is_signed_i & (op_1_i[31] ^ op_2_i[31]);
                        neg_r_q   <= is_signed_i & op_1_i[31];
                        if (div_zero) begin
                            quo_q   <= DIV_BY_ZERO_Q;
                            rem_q   <= op_1_i;
                            state_q <= S_DONE;
                        end else if (overflow) begin
                            quo_q   <= INT32_MIN;
                            rem_q   <= 32'd0;
                            state_q <= S_DONE;
                        end else begin
                            dvd_q   <= abs_if(op_1_i, is_signed_i);
                            dvs_q   <= abs_if(op_2_i, is_signed_i);
                            rem_q   <= 32'd0;
                            quo_q   <= 32'd0;
                            count_q <= 5'd0;
                            state_q <= S_DIV;
                        end
                    end
                end
                S_DIV: begin
                    rem_q   <= step_rem;
                    quo_q   <= {quo_q[30:0], step_q_bit};
                    dvd_q   <= {dvd_q[30:0], 1'b0};
                    count_q <= count_q + 5'd1;
                    if (count_q == DIV_LAST_STEP) begin
                        state_q <= S_FINALIZE;
                    end
                end
                S_FINALIZE: begin
                    quo_q   <= neg_if(quo_q, neg_q_q);
                    rem_q   <= neg_if(rem_q, neg_r_q);
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    // A request withdrawn mid-flight is dropped so no stale ack can leak.
                    if (stb_i) begin
                        result_q   <= rem_sel_q ? rem_q : quo_q;
                        sync_ack_q <= 1'b1;
                    end
                    state_q <= S_START;
                end
                default: begin
                    state_q <= S_START;
                end
            endcase
        end
    end

    assign result_o = result_q;
    assign ack_o    = sync_ack_q & stb_i;

endmodule

// File: tb/tb_divider.sv
// Randomized bench for divider against a plain 64-bit arithmetic model,
// covering handshake abort, ignored requests and asynchronous reset.
module tb_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stb;
    logic        cyc;
    logic [31:0] op_1;
    logic [31:0] op_2;
    logic        is_signed;
    logic        rem_sel;
    logic [31:0] result;
    logic        ack;

    int          tests = 0;
    int          fails = 0;
    logic        mon_en = 1'b0;
    logic        pending = 1'b0;
    logic [31:0] exp_res = 32'd0;
    logic [31:0] last_res = 32'd0;

    always #5 clk = ~clk;

    divider dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .stb_i        (stb),
        .cyc_i        (cyc),
        .op_1_i       (op_1),
        .op_2_i       (op_2),
        .is_signed_i  (is_signed),
        .result_rem_i (rem_sel),
        .result_o     (result),
        .ack_o        (ack)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // RISC-V division semantics from wide signed arithmetic (truncating toward zero).
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input bit s, input bit r);
        longint na, nb, q, m;
        if (s) begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
        end else begin
            na = longint'({32'd0, a});
            nb = longint'({32'd0, b});
        end
        if (nb == 0) begin
            q = -1;
            m = na;
        end else begin
            q = na / nb;
            m = na % nb;
        end
        return r ? m[31:0] : q[31:0];
    endfunction

    function automatic int model_lat(input logic [31:0] a, input logic [31:0] b, input bit s);
        return (b == 32'd0 || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 2 : 35;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 50));
            default: return $urandom();
        endcase
    endfunction

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            check("stale_ack", {31'd0, ack & ~pending}, 32'd0);
            check("result", result, ack ? exp_res : last_res);
        end
    end

    // Called at posedge+2; returns at posedge+2 after one idle clock with stb low.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input bit s, input bit r, input int hold);
        int n;
        exp_res   = model(a, b, s, r);
        op_1      = a;
        op_2      = b;
        is_signed = s;
        rem_sel   = r;
        pending   = 1'b1;
        stb       = 1'b1;
        cyc       = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!ack && n < 100);
        check("latency", 32'(n), 32'(model_lat(a, b, s)));
        repeat (hold) @(posedge clk);
        @(posedge clk);
        #2;
        stb      = 1'b0;
        cyc      = 1'b0;
        pending  = 1'b0;
        last_res = exp_res;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        stb = 1'b0;
        cyc = 1'b0;
        op_1 = 32'd0;
        op_2 = 32'd0;
        is_signed = 1'b0;
        rem_sel = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("reset_result", result, 32'd0);
        check("reset_ack", {31'd0, ack}, 32'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #2;

        check("model_divu_q", model(32'd20, 32'd3, 0, 0), 32'd6);
        check("model_remu", model(32'd20, 32'd3, 0, 1), 32'd2);
        check("model_div_neg", model(32'hFFFF_FFEC, 32'd3, 1, 0), 32'hFFFF_FFFA);
        check("model_rem_neg", model(32'hFFFF_FFEC, 32'd3, 1, 1), 32'hFFFF_FFFE);
        check("model_div_nn", model(32'hFFFF_FFEC, 32'hFFFF_FFFD, 1, 0), 32'd6);
        check("model_rem_nn", model(32'hFFFF_FFEC, 32'hFFFF_FFFD, 1, 1), 32'hFFFF_FFFE);
        check("model_div0_q", model(32'h1234, 32'd0, 1, 0), 32'hFFFF_FFFF);
        check("model_div0_r", model(32'h1234, 32'd0, 0, 1), 32'h1234);
        check("model_ovf_q", model(32'h8000_0000, 32'hFFFF_FFFF, 1, 0), 32'h8000_0000);
        check("model_ovf_r", model(32'h8000_0000, 32'hFFFF_FFFF, 1, 1), 32'd0);
        check("model_u_q", model(32'h8000_0000, 32'hFFFF_FFFF, 0, 0), 32'd0);
        check("model_u_r", model(32'h8000_0000, 32'hFFFF_FFFF, 0, 1), 32'h8000_0000);
        check("model_100_7", model(32'd100, 32'd7, 0, 0), 32'd14);

        run_op(32'd20, 32'd3, 0, 0, 5);
        run_op(32'd20, 32'd3, 0, 1, 0);
        run_op(32'hFFFF_FFEC, 32'd3, 1, 0, 0);
        run_op(32'hFFFF_FFEC, 32'd3, 1, 1, 0);
        run_op(32'hFFFF_FFEC, 32'hFFFF_FFFD, 1, 0, 0);
        run_op(32'hFFFF_FFEC, 32'hFFFF_FFFD, 1, 1, 5);
        run_op(32'h1234, 32'd0, 1, 0, 0);
        run_op(32'h1234, 32'd0, 0, 1, 2);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1, 1, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 0);

        // stb without cyc must be ignored
        op_1 = 32'd77;
        op_2 = 32'd5;
        is_signed = 1'b0;
        rem_sel = 1'b0;
        stb = 1'b1;
        cyc = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        stb = 1'b0;
        @(posedge clk);
        #2;
        run_op(32'd77, 32'd5, 0, 1, 0);

        // aborted request: result discarded, no ack, later request unaffected
        op_1 = 32'd999;
        op_2 = 32'd4;
        stb = 1'b1;
        cyc = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        stb = 1'b0;
        cyc = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        run_op(32'hDEAD_BEEF, 32'd13, 1, 0, 0);

        for (int i = 0; i < 40; i++) begin
            run_op(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 2)));
        end

        // asynchronous reset between edges in the middle of a division
        run_op(32'd1000, 32'd3, 0, 0, 0);
        op_1 = 32'hFFFF;
        op_2 = 32'd5;
        stb = 1'b1;
        cyc = 1'b1;
        repeat (15) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_ack", {31'd0, ack}, 32'd0);
        check("async_rst_result", result, 32'd0);
        last_res = 32'd0;
        stb = 1'b0;
        cyc = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        run_op(32'd100, 32'd7, 0, 0, 0);
        check("after_reset_100_7", result, 32'd14);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
